// File: rtl/temporizador_multirate.sv
`default_nettype none
// ============================================================================
// temporizador_multirate
//   Multirate audio timing generator: fractional-accumulator sample clocks,
//   glitch-free selectable sample clock, debounced reset, 1/2 s and heartbeat.
//   Revision: 1.0
// ============================================================================
module temporizador_multirate #(
  parameter int CLK_HZ  = 60_000_000,
  parameter int ACC_W   = 32,
  parameter int DEB_CYC = 6000,
  parameter int HB_CYC  = CLK_HZ / 10
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       reset_btn,
  input  logic [2:0] rate_sel,
  output logic [7:0] samp_rates,
  output logic [7:0] samp_ticks,
  output logic       sample_clk,
  output logic       sample_tick,
  output logic       rst_out,
  output logic       medio_sg,
  output logic       latido
);

  localparam int C_DEB_W  = $clog2(DEB_CYC + 1);
  localparam int C_HALF   = CLK_HZ / 2;
  localparam int C_SEC_W  = $clog2(C_HALF + 1);
  localparam int C_HB_W   = $clog2(HB_CYC + 1);

  localparam logic [C_DEB_W-1:0] C_DEB      = C_DEB_W'(DEB_CYC);
  localparam logic [C_SEC_W-1:0] C_SEC_LAST = C_SEC_W'(C_HALF - 1);
  localparam logic [C_HB_W-1:0]  C_HB_LAST  = C_HB_W'(HB_CYC - 1);

  function automatic int f_rate_hz(input int idx);
    case (idx)
      0:       return 8000;
      1:       return 11025;
      2:       return 16000;
      3:       return 22050;
      4:       return 24000;
      5:       return 32000;
      6:       return 44100;
      default: return 48000;
    endcase
  endfunction

  // Rounded phase increment: (rate * 2^ACC_W + CLK_HZ/2) / CLK_HZ.
  function automatic logic [63:0] f_inc(input int idx);
    return ((64'(f_rate_hz(idx)) << ACC_W) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
  endfunction

  logic [1:0]         r_sync;
  logic               r_rst_out;
  logic [C_DEB_W-1:0] r_deb;
  logic [C_SEC_W-1:0] r_sec;
  logic               r_medio;
  logic               r_latido;
  logic [C_HB_W-1:0]  r_hb;
  logic [2:0]         r_sel;
  logic [7:0]         w_rates;
  logic [7:0]         w_ticks;
  logic               w_hold;

  assign w_hold = !reset_n || r_rst_out;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_chan
      localparam logic [63:0]      C_INC64 = f_inc(i);
      localparam logic [ACC_W-1:0] C_INC   = C_INC64[ACC_W-1:0];

      logic [ACC_W-1:0] r_acc;
      logic             r_rate;
      logic             r_tick;
      logic [ACC_W:0]   w_sum;

      assign w_sum = {1'b0, r_acc} + {1'b0, C_INC};

      always_ff @(posedge clock_in) begin
        if (w_hold) begin
          r_acc  <= '0;
          r_rate <= 1'b0;
          r_tick <= 1'b0;
        end else begin
          r_acc  <= w_sum[ACC_W-1:0];
          r_rate <= w_sum[ACC_W-1];
          r_tick <= w_sum[ACC_W];
        end
      end

      assign w_rates[i] = r_rate;
      assign w_ticks[i] = r_tick;
    end
  endgenerate

  // Button synchroniser and debounce; any synchronised high level restarts the hold.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_sync    <= 2'b00;
      r_rst_out <= 1'b1;
      r_deb     <= C_DEB;
    end else begin
      r_sync <= {r_sync[0], reset_btn};
      if (r_sync[1]) begin
        r_rst_out <= 1'b1;
        r_deb     <= C_DEB;
      end else if (r_rst_out) begin
        r_deb <= r_deb - 1'b1;
        if (r_deb == C_DEB_W'(1)) begin
          r_rst_out <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (w_hold) begin
      r_sec    <= '0;
      r_medio  <= 1'b0;
      r_latido <= 1'b0;
      r_hb     <= '0;
    end else begin
      if (r_sec == C_SEC_LAST) begin
        r_sec   <= '0;
        r_medio <= ~r_medio;
      end else begin
        r_sec <= r_sec + 1'b1;
      end
      if (r_sec == C_SEC_LAST && !r_medio) begin
        r_latido <= 1'b1;
        r_hb     <= C_HB_LAST;
      end else if (r_latido) begin
        if (r_hb == '0) begin
          r_latido <= 1'b0;
        end else begin
          r_hb <= r_hb - 1'b1;
        end
      end
    end
  end

  // Selection only moves on the current channel's tick, so its period is never cut short.
  always_ff @(posedge clock_in) begin
    if (w_hold || w_ticks[r_sel]) begin
      r_sel <= rate_sel;
    end
  end

  assign samp_rates  = w_rates;
  assign samp_ticks  = w_ticks;
  assign sample_clk  = w_rates[r_sel];
  assign sample_tick = w_ticks[r_sel];
  assign rst_out     = r_rst_out;
  assign medio_sg    = r_medio;
  assign latido      = r_latido;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_multirate.sv
`default_nettype none
// ============================================================================
// tb_temporizador_multirate
//   Directed bench: channel division/counts, debounce, selection, 1/2 s, reset.
//   Revision: 1.0
// ============================================================================
module tb_temporizador_multirate;

  localparam int A_DEB = 20;
  localparam int B_DEB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       a_rstn, a_btn;
  logic [2:0] a_sel;
  logic [7:0] a_rates, a_ticks;
  logic       a_sclk, a_stick, a_rst, a_medio, a_lat;

  logic       b_rstn;
  logic [7:0] b_rates, b_ticks;
  logic       b_sclk, b_stick, b_rst, b_medio, b_lat;

  temporizador_multirate #(
    .CLK_HZ(1536000), .ACC_W(16), .DEB_CYC(A_DEB), .HB_CYC(1000)
  ) u_dut_a (
    .clock_in(clk), .reset_n(a_rstn), .reset_btn(a_btn), .rate_sel(a_sel),
    .samp_rates(a_rates), .samp_ticks(a_ticks), .sample_clk(a_sclk),
    .sample_tick(a_stick), .rst_out(a_rst), .medio_sg(a_medio), .latido(a_lat)
  );

  temporizador_multirate #(
    .CLK_HZ(1000), .ACC_W(16), .DEB_CYC(B_DEB), .HB_CYC(100)
  ) u_dut_b (
    .clock_in(clk), .reset_n(b_rstn), .reset_btn(1'b0), .rate_sel(3'd0),
    .samp_rates(b_rates), .samp_ticks(b_ticks), .sample_clk(b_sclk),
    .sample_tick(b_stick), .rst_out(b_rst), .medio_sg(b_medio), .latido(b_lat)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_a();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_wait_rst(input logic lvl, output int n);
    n = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick_a();
      if (a_rst === lvl) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic b_wait_rst(input logic lvl, output int n);
    n = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick_a();
      if (b_rst === lvl) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_a();
    int n;
    int cnt [0:7];
    int exp_inc [0:7];
    int ft [0:7];
    int hi7, bad_per, bad_fall, st_cnt, last, mis, lows;
    logic prev7;
    exp_inc = '{341, 470, 683, 941, 1024, 1365, 1882, 2048};

    a_rstn = 1'b0; a_btn = 1'b0; a_sel = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_reset_rst_out", int'(a_rst), 1);
    check("a_reset_rates", int'(a_rates), 0);
    check("a_reset_ticks", int'(a_ticks), 0);
    check("a_reset_sample", int'({a_sclk, a_stick}), 0);
    check("a_reset_medio_latido", int'({a_medio, a_lat}), 0);

    a_rstn = 1'b1;
    a_wait_rst(1'b0, n);
    check("a_deb_after_release", n, A_DEB);

    // 65536-cycle window from the rst_out fall: every channel yields exactly INC ticks.
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    hi7 = 0; bad_per = 0; bad_fall = 0; st_cnt = 0; last = -1; prev7 = 1'b0;
    for (int c = 1; c <= 65536; c++) begin
      tick_a();
      for (int i = 0; i < 8; i++) if (a_ticks[i]) cnt[i]++;
      hi7 += int'(a_rates[7]);
      if (a_ticks[7]) begin
        if (last >= 0 && c - last != 32) bad_per++;
        last = c;
        if (!(prev7 && !a_rates[7])) bad_fall++;
      end else if (prev7 && !a_rates[7]) begin
        bad_fall++;
      end
      if (a_stick) st_cnt++;
      prev7 = a_rates[7];
    end
    for (int i = 0; i < 8; i++) check($sformatf("a_tick_count_ch%0d", i), cnt[i], exp_inc[i]);
    check("a_48k_high_cycles", hi7, 32768);
    check("a_48k_bad_periods", bad_per, 0);
    check("a_48k_tick_not_on_fall", bad_fall, 0);
    check("a_sample_tick_count", st_cnt, 2048);

    // Selection change mid-period, with a second change before the tick.
    n = -1;
    for (int k = 1; k <= 64; k++) begin
      tick_a();
      if (a_ticks[7]) begin n = k; break; end
    end
    check("a_sel_found_tick", int'(n > 0), 1);
    mis = 0;
    repeat (10) begin tick_a(); if (a_sclk !== a_rates[7]) mis++; end
    a_sel = 3'd3;
    repeat (5) begin tick_a(); if (a_sclk !== a_rates[7]) mis++; end
    a_sel = 3'd0;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick_a();
      if (a_sclk !== a_rates[7]) mis++;
      if (a_stick) begin n = k; break; end
    end
    check("a_sel_old_channel_kept", mis, 0);
    check("a_sel_wait_to_tick", n, 17);
    check("a_sel_tick_is_48k", int'(a_ticks[7]), 1);
    mis = 0;
    repeat (400) begin
      tick_a();
      if (a_sclk !== a_rates[0] || a_stick !== a_ticks[0]) mis++;
    end
    check("a_sel_follows_8k", mis, 0);

    // Debounce: hold 50 cycles, then 0/1/0 bounce at 5 cycles per level.
    a_btn = 1'b1;
    a_wait_rst(1'b1, n);
    check("a_btn_to_rst_out", n, 3);
    lows = 0;
    repeat (47) begin tick_a(); if (!a_rst) lows++; end
    a_btn = 1'b0;
    repeat (5) begin tick_a(); if (!a_rst) lows++; end
    a_btn = 1'b1;
    repeat (5) begin tick_a(); if (!a_rst) lows++; end
    a_btn = 1'b0;
    check("a_rst_out_held_in_bounce", lows, 0);
    a_wait_rst(1'b0, n);
    check("a_btn_release_to_fall", n, A_DEB + 2);
    check("a_restart_rates_zero", int'(a_rates), 0);
    for (int i = 0; i < 8; i++) ft[i] = -1;
    for (int c = 1; c <= 80; c++) begin
      tick_a();
      for (int i = 0; i < 8; i++) if (a_ticks[i] && ft[i] < 0) ft[i] = c;
    end
    check("a_restart_first_tick_48k", ft[7], 32);
    check("a_restart_first_tick_44k1", ft[6], 35);
    check("a_restart_first_tick_22k05", ft[3], 70);

    // One-cycle synchronous reset mid-run.
    repeat (100) tick_a();
    a_sel  = 3'd5;
    a_rstn = 1'b0;
    tick_a();
    check("a_mid_reset_rst_out", int'(a_rst), 1);
    check("a_mid_reset_rates", int'(a_rates), 0);
    check("a_mid_reset_ticks", int'(a_ticks), 0);
    check("a_mid_reset_sample_clk", int'(a_sclk), 0);
    a_rstn = 1'b1;
    a_wait_rst(1'b0, n);
    check("a_mid_reset_deb", n, A_DEB);
    mis = 0; st_cnt = 0;
    repeat (300) begin
      tick_a();
      if (a_sclk !== a_rates[5] || a_stick !== a_ticks[5]) mis++;
      if (a_stick) st_cnt++;
    end
    check("a_sel5_follows_32k", mis, 0);
    check("a_sel5_ticks_300", st_cnt, 6);
  endtask

  task automatic test_b();
    int n, first, tog, bad, lat_hi, lat_rise, bad_lat, last_t;
    logic pm, pl;
    b_rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b_reset_rst_out", int'(b_rst), 1);
    check("b_reset_medio_latido", int'({b_medio, b_lat}), 0);
    b_rstn = 1'b1;
    b_wait_rst(1'b0, n);
    check("b_deb_after_release", n, B_DEB);
    first = -1; tog = 0; bad = 0; lat_hi = 0; lat_rise = 0; bad_lat = 0; last_t = 0;
    pm = 1'b0; pl = 1'b0;
    for (int c = 1; c <= 2100; c++) begin
      tick_a();
      if (b_medio !== pm) begin
        tog++;
        if (first < 0) first = c;
        else if (c - last_t != 500) bad++;
        last_t = c;
        if (b_medio && !b_lat) bad_lat++;
      end
      if (b_lat) lat_hi++;
      if (b_lat && !pl) begin
        lat_rise++;
        if (!(b_medio && !pm)) bad_lat++;
      end
      pm = b_medio;
      pl = b_lat;
    end
    check("b_first_toggle", first, 500);
    check("b_toggle_count", tog, 4);
    check("b_toggle_interval_errors", bad, 0);
    check("b_latido_high_cycles", lat_hi, 200);
    check("b_latido_rises", lat_rise, 2);
    check("b_latido_alignment_errors", bad_lat, 0);
  endtask

  initial begin
    a_rstn = 1'b0; a_btn = 1'b0; a_sel = 3'd7; b_rstn = 1'b0;
    fork
      test_a();
      test_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
